// File: rtl/writeback_queue_if.sv
// Request, register-file write-port and forwarding-lookup signals of the writeback queue.
// The master side is the producers/lookup logic; the slave side is the queue itself.
interface writeback_queue_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_reg;
    logic [31:0] mem_data;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        wb_hold;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic        Fwd1Hit;
    logic        Fwd2Hit;
    logic [31:0] Fwd1Data;
    logic [31:0] Fwd2Data;

    modport master (
        output mem_valid, mem_reg, mem_data,
        output alu_valid, alu_reg, alu_data,
        output wb_hold, ReadReg1, ReadReg2,
        input  mem_ready, alu_ready,
        input  RegWrite, WriteReg, WriteData,
        input  Fwd1Hit, Fwd2Hit, Fwd1Data, Fwd2Data
    );

    modport slave (
        input  mem_valid, mem_reg, mem_data,
        input  alu_valid, alu_reg, alu_data,
        input  wb_hold, ReadReg1, ReadReg2,
        output mem_ready, alu_ready,
        output RegWrite, WriteReg, WriteData,
        output Fwd1Hit, Fwd2Hit, Fwd1Data, Fwd2Data
    );
endinterface

// File: rtl/writeback_queue.sv
// Register-file writeback queue: arbitrates memory/ALU results into a circular FIFO,
// drains one registered write per cycle and forwards pending writes to two lookup ports.
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    writeback_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t        fifo_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          reg_write_q, reg_write_d;
    logic [4:0]    write_reg_q, write_reg_d;
    logic [31:0]   write_data_q, write_data_d;

    logic          not_full;
    logic          mem_fire;
    logic          alu_fire;
    logic          push_en;
    logic          pop_en;
    logic [4:0]    push_reg;
    logic [31:0]   push_data;

    assign not_full      = count_q < CW'(DEPTH);
    assign bus.mem_ready = not_full;
    assign bus.alu_ready = not_full & ~bus.mem_valid;

    assign mem_fire  = bus.mem_valid & not_full;
    assign alu_fire  = bus.alu_valid & not_full & ~bus.mem_valid;
    assign push_reg  = mem_fire ? bus.mem_reg  : bus.alu_reg;
    assign push_data = mem_fire ? bus.mem_data : bus.alu_data;

    // Writes to the protected registers complete their handshake but never enter the queue.
    assign push_en = (mem_fire | alu_fire) & (push_reg != 5'd0) & (push_reg != 5'd31);
    assign pop_en  = (count_q != '0) & ~bus.wb_hold;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        reg_write_d  = 1'b0;
        write_reg_d  = '0;
        write_data_d = '0;
        if (pop_en) begin
            head_d       = head_q + PW'(1);
            reg_write_d  = 1'b1;
            write_reg_d  = fifo_q[head_q].rd;
            write_data_d = fifo_q[head_q].data;
        end
        if (push_en) begin
            tail_d = tail_q + PW'(1);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    // NOTE: the entry storage is not reset; count/head/tail alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_en) begin
            fifo_q[tail_q] <= '{rd: push_reg, data: push_data};
        end
    end

    assign bus.RegWrite  = reg_write_q;
    assign bus.WriteReg  = write_reg_q;
    assign bus.WriteData = write_data_q;

    logic [1:0][4:0]  look_reg;
    logic [1:0]       look_hit;
    logic [1:0][31:0] look_data;
    logic [PW-1:0]    look_idx;

    assign look_reg = {bus.ReadReg2, bus.ReadReg1};

    // Scan oldest to youngest so a younger match overrides; the output register is the oldest write.
    always_comb begin
        look_idx  = head_q;
        look_hit  = '0;
        look_data = '0;
        for (int p = 0; p < 2; p++) begin
            if (reg_write_q && write_reg_q == look_reg[p]) begin
                look_hit[p]  = 1'b1;
                look_data[p] = write_data_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                look_idx = head_q + PW'(i);
                if (CW'(i) < count_q && fifo_q[look_idx].rd == look_reg[p]) begin
                    look_hit[p]  = 1'b1;
                    look_data[p] = fifo_q[look_idx].data;
                end
            end
            if (look_reg[p] == 5'd0 || look_reg[p] == 5'd31) begin
                look_hit[p]  = 1'b0;
                look_data[p] = '0;
            end
        end
    end

    assign bus.Fwd1Hit  = look_hit[0];
    assign bus.Fwd2Hit  = look_hit[1];
    assign bus.Fwd1Data = look_data[0];
    assign bus.Fwd2Data = look_data[1];
endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the writeback behaviour.
module tb_writeback_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    writeback_queue_if bus ();
    writeback_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    // Reference model: pending writes in acceptance order plus the register-file write port.
    ent_t        mq [$];
    logic        m_rw;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;

    // Every committed write as seen by the register file, one entry per RegWrite cycle.
    ent_t obs [$];
    always @(negedge clk) begin
        ent_t o;
        if (bus.RegWrite === 1'b1) begin
            o.r = bus.WriteReg;
            o.d = bus.WriteData;
            obs.push_back(o);
        end
    end

    function automatic void model_reset();
        mq.delete();
        m_rw = 1'b0;
        m_wr = '0;
        m_wd = '0;
    endfunction

    function automatic void model_edge();
        ent_t e;
        bit   room;
        room = mq.size() < DEPTH;
        if (mq.size() > 0 && !bus.wb_hold) begin
            e    = mq.pop_front();
            m_rw = 1'b1;
            m_wr = e.r;
            m_wd = e.d;
        end else begin
            m_rw = 1'b0;
            m_wr = '0;
            m_wd = '0;
        end
        if (room && bus.mem_valid) begin
            e.r = bus.mem_reg;
            e.d = bus.mem_data;
        end else if (room && bus.alu_valid) begin
            e.r = bus.alu_reg;
            e.d = bus.alu_data;
        end else begin
            e.r = 5'd0;
        end
        if (e.r != 5'd0 && e.r != 5'd31) mq.push_back(e);
    endfunction

    function automatic void model_fwd(input logic [4:0] r, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (r == 5'd0 || r == 5'd31) return;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].r == r) begin
                hit = 1'b1;
                d   = mq[i].d;
                return;
            end
        end
        if (m_rw && m_wr == r) begin
            hit = 1'b1;
            d   = m_wd;
        end
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.mem_valid = 1'b0;
        bus.alu_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ReadReg1 = 5'd5;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %b want 0", bus.RegWrite); end
        checks++; if (bus.WriteReg !== 5'd0) begin errors++; $display("FAIL reset_writereg got %0d want 0", bus.WriteReg); end
        checks++; if (bus.WriteData !== 32'd0) begin errors++; $display("FAIL reset_writedata got %h want 0", bus.WriteData); end
        checks++; if (bus.Fwd1Hit !== 1'b0 || bus.Fwd1Data !== 32'd0) begin errors++; $display("FAIL reset_fwd got %b/%h want 0/0", bus.Fwd1Hit, bus.Fwd1Data); end
        rst = 1'b0;
        model_reset();
        bus.mem_valid = 1'b1;
        #1;
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_ready got %b want 1", bus.mem_ready); end
        checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready_memvalid got %b want 0", bus.alu_ready); end
        bus.mem_valid = 1'b0;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready got %b want 1", bus.alu_ready); end
    endtask

    task automatic test_single();
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 5'd5;
        bus.alu_data  = 32'h1234_5678;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", bus.alu_ready); end
        tick();
        idle();
        obs.delete();
        checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", bus.RegWrite); end
        checks++; if (bus.Fwd1Hit !== 1'b1 || bus.Fwd1Data !== 32'h1234_5678) begin errors++; $display("FAIL single_fwd got %b/%h want 1/12345678", bus.Fwd1Hit, bus.Fwd1Data); end
        tick();
        checks++; if (bus.RegWrite !== 1'b1 || bus.WriteReg !== 5'd5 || bus.WriteData !== 32'h1234_5678) begin
            errors++; $display("FAIL single_write got %b/%0d/%h want 1/5/12345678", bus.RegWrite, bus.WriteReg, bus.WriteData);
        end
        repeat (3) tick();
        checks++; if (obs.size() != 1) begin errors++; $display("FAIL single_pulses got %0d want 1", obs.size()); end
    endtask

    task automatic test_priority();
        ent_t exp [$];
        obs.delete();
        bus.mem_valid = 1'b1; bus.mem_reg = 5'd3; bus.mem_data = 32'hA;
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd4; bus.alu_data = 32'hB;
        #1;
        checks++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin errors++; $display("FAIL prio_ready got %b/%b want 1/0", bus.mem_ready, bus.alu_ready); end
        tick();
        tick();
        bus.mem_valid = 1'b0;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL prio_alu_ready got %b want 1", bus.alu_ready); end
        tick();
        idle();
        repeat (4) tick();
        exp = '{'{5'd3, 32'hA}, '{5'd3, 32'hA}, '{5'd4, 32'hB}};
        checks++; if (obs.size() != exp.size()) begin errors++; $display("FAIL prio_count got %0d want %0d", obs.size(), exp.size()); end
        else for (int i = 0; i < exp.size(); i++) begin
            checks++; if (obs[i].r !== exp[i].r || obs[i].d !== exp[i].d) begin errors++; $display("FAIL prio_order[%0d] got %0d/%h want %0d/%h", i, obs[i].r, obs[i].d, exp[i].r, exp[i].d); end
        end
    endtask

    task automatic test_full_wrap();
        ent_t exp [$];
        ent_t e;
        obs.delete();
        bus.wb_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_reg   = 5'(i);
            bus.alu_data  = 32'h100 + 32'(i);
            e.r = 5'(i); e.d = 32'h100 + 32'(i); exp.push_back(e);
            tick();
        end
        bus.alu_reg  = 5'd9;
        bus.alu_data = 32'h109;
        #1;
        checks++; if (bus.mem_ready !== 1'b0 || bus.alu_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b/%b want 0/0", bus.mem_ready, bus.alu_ready); end
        checks++; if (dut.count_q !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", dut.count_q); end
        repeat (2) tick();
        checks++; if (bus.RegWrite !== 1'b0 || bus.alu_ready !== 1'b0) begin errors++; $display("FAIL full_stall got %b/%b want 0/0", bus.RegWrite, bus.alu_ready); end
        bus.wb_hold = 1'b0;
        tick();
        checks++; if (bus.RegWrite !== 1'b1 || bus.WriteReg !== 5'd1) begin errors++; $display("FAIL full_first_pop got %b/%0d want 1/1", bus.RegWrite, bus.WriteReg); end
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL full_reopen got %b want 1", bus.alu_ready); end
        e.r = 5'd9; e.d = 32'h109; exp.push_back(e);
        tick();
        for (int i = 0; i < 6; i++) begin
            bus.alu_reg  = 5'(10 + i);
            bus.alu_data = 32'h200 + 32'(i);
            e.r = 5'(10 + i); e.d = 32'h200 + 32'(i); exp.push_back(e);
            tick();
        end
        idle();
        repeat (10) tick();
        checks++; if (obs.size() != exp.size()) begin errors++; $display("FAIL wrap_count got %0d want %0d", obs.size(), exp.size()); end
        else for (int i = 0; i < exp.size(); i++) begin
            checks++; if (obs[i].r !== exp[i].r || obs[i].d !== exp[i].d) begin errors++; $display("FAIL wrap_order[%0d] got %0d/%h want %0d/%h", i, obs[i].r, obs[i].d, exp[i].r, exp[i].d); end
        end
    endtask

    task automatic test_protected();
        obs.delete();
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd0; bus.alu_data = 32'hFFFF_FFFF;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL prot_r0_ready got %b want 1", bus.alu_ready); end
        tick();
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b1; bus.mem_reg = 5'd31; bus.mem_data = 32'hFFFF_FFFF;
        #1;
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL prot_r31_ready got %b want 1", bus.mem_ready); end
        tick();
        idle();
        bus.ReadReg1 = 5'd0;
        bus.ReadReg2 = 5'd31;
        #1;
        checks++; if (bus.Fwd1Hit !== 1'b0 || bus.Fwd2Hit !== 1'b0) begin errors++; $display("FAIL prot_fwd got %b/%b want 0/0", bus.Fwd1Hit, bus.Fwd2Hit); end
        checks++; if (dut.count_q !== 3'd0) begin errors++; $display("FAIL prot_count got %0d want 0", dut.count_q); end
        repeat (3) tick();
        checks++; if (obs.size() != 0) begin errors++; $display("FAIL prot_writes got %0d want 0", obs.size()); end
    endtask

    task automatic test_forward();
        logic        eh;
        logic [31:0] ed;
        bus.wb_hold = 1'b1;
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd7; bus.alu_data = 32'h11;
        tick();
        bus.alu_data = 32'h22;
        tick();
        idle();
        bus.ReadReg1 = 5'd7;
        bus.ReadReg2 = 5'd8;
        #1;
        checks++; if (bus.Fwd1Hit !== 1'b1 || bus.Fwd1Data !== 32'h22) begin errors++; $display("FAIL fwd_youngest got %b/%h want 1/22", bus.Fwd1Hit, bus.Fwd1Data); end
        checks++; if (bus.Fwd2Hit !== 1'b0 || bus.Fwd2Data !== 32'd0) begin errors++; $display("FAIL fwd_miss got %b/%h want 0/0", bus.Fwd2Hit, bus.Fwd2Data); end
        bus.wb_hold = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            model_fwd(bus.ReadReg1, eh, ed);
            checks++; if (bus.Fwd1Hit !== eh || bus.Fwd1Data !== ed) begin errors++; $display("FAIL fwd_drain[%0d] got %b/%h want %b/%h", c, bus.Fwd1Hit, bus.Fwd1Data, eh, ed); end
        end
        checks++; if (bus.Fwd1Hit !== 1'b0) begin errors++; $display("FAIL fwd_committed got %b want 0", bus.Fwd1Hit); end
    endtask

    task automatic test_reset_mid();
        obs.delete();
        bus.wb_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_reg   = 5'(20 + i);
            bus.alu_data  = 32'h300 + 32'(i);
            tick();
        end
        idle();
        bus.wb_hold = 1'b0;
        tick();
        checks++; if (bus.RegWrite !== 1'b1 || bus.WriteReg !== 5'd20) begin errors++; $display("FAIL rstmid_setup got %b/%0d want 1/20", bus.RegWrite, bus.WriteReg); end
        bus.ReadReg1 = 5'd21;
        #1;
        rst = 1'b1;
        #1;
        checks++; if (bus.RegWrite !== 1'b0 || bus.WriteReg !== 5'd0 || bus.WriteData !== 32'd0) begin
            errors++; $display("FAIL rstmid_drop got %b/%0d/%h want 0/0/0", bus.RegWrite, bus.WriteReg, bus.WriteData);
        end
        checks++; if (bus.Fwd1Hit !== 1'b0) begin errors++; $display("FAIL rstmid_fwd got %b want 0", bus.Fwd1Hit); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b/%b want 1/1", bus.mem_ready, bus.alu_ready); end
        checks++; if (dut.count_q !== 3'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", dut.count_q); end
        repeat (6) tick();
        checks++; if (obs.size() != 0) begin errors++; $display("FAIL rstmid_writes got %0d want 0", obs.size()); end
    endtask

    function automatic logic [4:0] pick_reg();
        int r;
        r = $urandom_range(0, 8);
        return (r == 8) ? 5'd31 : 5'(r);
    endfunction

    task automatic test_back_to_back();
        logic        eh;
        logic [31:0] ed;
        for (int n = 0; n < 600; n++) begin
            bus.wb_hold   = ($urandom_range(0, 9) < 3);
            bus.mem_valid = ($urandom_range(0, 2) == 0);
            bus.mem_reg   = pick_reg();
            bus.mem_data  = $urandom;
            bus.alu_valid = ($urandom_range(0, 1) == 0);
            bus.alu_reg   = pick_reg();
            bus.alu_data  = $urandom;
            bus.ReadReg1  = pick_reg();
            bus.ReadReg2  = pick_reg();
            #1;
            model_fwd(bus.ReadReg1, eh, ed);
            checks++; if (bus.Fwd1Hit !== eh || bus.Fwd1Data !== ed) begin errors++; $display("FAIL rnd_fwd1[%0d] got %b/%h want %b/%h", n, bus.Fwd1Hit, bus.Fwd1Data, eh, ed); end
            model_fwd(bus.ReadReg2, eh, ed);
            checks++; if (bus.Fwd2Hit !== eh || bus.Fwd2Data !== ed) begin errors++; $display("FAIL rnd_fwd2[%0d] got %b/%h want %b/%h", n, bus.Fwd2Hit, bus.Fwd2Data, eh, ed); end
            checks++; if (bus.mem_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_mem_ready[%0d] got %b want %b", n, bus.mem_ready, mq.size() < DEPTH); end
            checks++; if (bus.alu_ready !== (mq.size() < DEPTH && !bus.mem_valid)) begin
                errors++; $display("FAIL rnd_alu_ready[%0d] got %b want %b", n, bus.alu_ready, mq.size() < DEPTH && !bus.mem_valid);
            end
            tick();
            checks++; if (bus.RegWrite !== m_rw || bus.WriteReg !== m_wr || bus.WriteData !== m_wd) begin
                errors++; $display("FAIL rnd_write[%0d] got %b/%0d/%h want %b/%0d/%h", n, bus.RegWrite, bus.WriteReg, bus.WriteData, m_rw, m_wr, m_wd);
            end
        end
        idle();
        bus.wb_hold = 1'b0;
        repeat (8) tick();
        checks++; if (bus.RegWrite !== 1'b0 || dut.count_q !== 3'd0) begin errors++; $display("FAIL rnd_drained got %b/%0d want 0/0", bus.RegWrite, dut.count_q); end
    endtask

    initial begin
        rst           = 1'b1;
        bus.mem_valid = 1'b0;
        bus.mem_reg   = '0;
        bus.mem_data  = '0;
        bus.alu_valid = 1'b0;
        bus.alu_reg   = '0;
        bus.alu_data  = '0;
        bus.wb_hold   = 1'b0;
        bus.ReadReg1  = '0;
        bus.ReadReg2  = '0;
        model_reset();
        test_reset();
        test_single();
        test_priority();
        test_full_wrap();
        test_protected();
        test_forward();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/writeback_queue.md
# writeback_queue

Buffers register-file write requests from the two result producers (ALU and data memory) and drives the single write port of the 32×32 register file (RegWrite, WriteReg, WriteData), one write per cycle. It sits between execute/memory stages and the register file. It also gives forwarding lookups for writes that are queued or in flight but not yet committed. Requests to register 0 and register 31 are absorbed and never committed, matching the register file's protected registers.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- mem_valid  in  1  memory result request.
- mem_ready  out  1  memory request accepted this edge.
- mem_reg  in  5  destination register.
- mem_data  in  32  write data.
- alu_valid  in  1  ALU result request.
- alu_ready  out  1  ALU request accepted this edge.
- alu_reg  in  5  destination register.
- alu_data  in  32  write data.
- wb_hold  in  1  suppresses popping of a new entry.
- RegWrite  out  1  register-file write enable (registered).
- WriteReg  out  5  register-file write address (registered).
- WriteData  out  32  register-file write data (registered).
- ReadReg1, ReadReg2  in  5 each  lookup addresses.
- Fwd1Hit, Fwd2Hit  out  1 each  a pending write to that register exists.
- Fwd1Data, Fwd2Data  out  32 each  data of the youngest pending write.

## Operation
- Circular FIFO of DEPTH entries, each {reg[4:0], data[31:0]}. Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. A separate count of 0..DEPTH distinguishes full from empty.
- Handshake: a transfer occurs at a rising edge with valid=1 and ready=1. At most one request is accepted per cycle.
  - mem_ready = (count < DEPTH).
  - alu_ready = (count < DEPTH) & ~mem_valid.
  - The memory port has fixed priority. Neither ready signal depends on wb_hold or on a same-cycle pop.
- An accepted request with reg = 0 or reg = 31 completes its handshake but is discarded: it is not enqueued, count is unchanged, and it is invisible to forwarding.
- Drain, at every edge:
  - If count > 0 and wb_hold = 0: pop the head into {WriteReg, WriteData} and set RegWrite = 1.
  - Otherwise: RegWrite = 0, WriteReg = 0, WriteData = 0.
- Simultaneous push and pop: both take effect. Count is unchanged, and the new entry is written at the tail while the head advances. When full, a push is not possible in that cycle even if a pop happens.
- Forwarding (combinational) for each of ReadReg1 and ReadReg2:
  - Search the valid queue entries from youngest (tail-1) to oldest (head), then the output register if RegWrite = 1.
  - The first match sets Hit = 1 and Data = that entry's data.
  - Otherwise Hit = 0 and Data = 0.
  - A lookup of register 0 or 31 always returns Hit = 0.

## Timing
- Reset (asynchronous):
  - count, head and tail go to 0.
  - RegWrite = 0, WriteReg = 0, WriteData = 0.
  - Fwd*Hit = 0 and Fwd*Data = 0 immediately.
  - mem_ready = 1, and alu_ready = ~mem_valid, in the first cycle after release.
- Reset asserted mid-operation: all queued and in-flight writes are dropped. No RegWrite pulse occurs during or after reset for the dropped entries.
- Latency with an empty queue and wb_hold = 0: request accepted at edge N, RegWrite = 1 with its data from edge N+1 to N+2, committed by the register file at edge N+2.
- Sustained throughput is one write per cycle. Each RegWrite pulse lasts exactly one cycle per entry, and entries retire in acceptance order.
- wb_hold = 1 at edge N: no pop at N, and RegWrite is 0 for the following cycle. An entry already in the output register is not affected.
- Forwarding covers a write from its acceptance edge until the edge at which the register file commits it. There is no gap in coverage.

## Test plan
- Single write: after reset, alu_valid=1, alu_reg=5, alu_data=32'h1234_5678 for one cycle -> exactly one cycle with RegWrite=1, WriteReg=5, WriteData=32'h1234_5678, one cycle after acceptance.
- Priority and ordering: mem (reg 3, 32'hA) and alu (reg 4, 32'hB) valid together for two cycles -> alu_ready=0 in cycle 1. Writes retire as reg 3/A, then reg 3/A again (second mem request), then reg 4/B only after mem_valid drops.
- Full and wrap: wb_hold=1, push DEPTH (4) entries with regs 1..4 -> ready=0 with count=4, and a fifth request stalls. Release hold -> four consecutive RegWrite pulses with regs 1,2,3,4, then push/pop across the pointer wrap with order preserved.
- Protected registers: requests to reg 0 and reg 31 with data 32'hFFFF_FFFF -> handshake completes, no RegWrite pulse, and Fwd*Hit=0 for ReadReg=0/31.
- Forwarding: queue reg 7 = 32'h11, then reg 7 = 32'h22, under hold; ReadReg1=7 -> Fwd1Hit=1, Fwd1Data=32'h22. After both drain and commit -> Fwd1Hit=0.
- Reset mid-operation: three entries queued and one in the output register, assert rst asynchronously -> RegWrite drops to 0 immediately, no writes after release, count=0, and ready is restored.
